// File: rtl/riscv_next_pc.sv
// riscv_next_pc -- next-PC selection for a single-issue RISC-V fetch stage.
// Resolves conditional branches, JAL and JALR from decode/ALU results, raises a
// misaligned-target trap (redirecting to TRAP_VEC and capturing the faulting PC
// in epc), and counts non-stalled cycles in retired.
module riscv_next_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [2:0]  funct3,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  input  logic        zero,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        trap_pending,
  output logic [31:0] epc,
  output logic [31:0] retired
);

  // Branch flavours carried in funct3; 010/011 are not branches and never take.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_trap_pending;
  logic [31:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_rel;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [31:0] w_next_pc;

  // Sequential link address and PC-relative target; both wrap modulo 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_rel   = r_pc + imm;

  // Branch condition: equality tests use the SUB zero flag, ordered compares
  // use the SLT/SLTU result that the ALU leaves in bit 0.
  always_comb begin
    // NOTE: default first so every path assigns w_cond and no latch is inferred.
    w_cond = 1'b0;
    case (funct3)
      F3_BEQ:           w_cond = zero;
      F3_BNE:           w_cond = ~zero;
      F3_BLT, F3_BLTU:  w_cond = alu_out[0];
      F3_BGE, F3_BGEU:  w_cond = ~alu_out[0];
      default:          w_cond = 1'b0;
    endcase
  end

  assign w_taken = jalr | jal | (branch & w_cond);

  // Target selection: JALR beats JAL beats branch; JALR clears bit 0.
  always_comb begin
    w_target = w_pc_rel;
    if (jalr) begin
      w_target = {alu_out[31:1], 1'b0};
    end
  end

  // Bit 1 can still be set on a JALR target, so both low bits are checked.
  assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

  // Next PC for a non-stalled cycle.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_misaligned) begin
      w_next_pc = TRAP_VEC;
    end else if (w_taken) begin
      w_next_pc = w_target;
    end
  end

  // PC, exception PC and retire counter; all frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_epc     <= 32'd0;
      r_retired <= 32'd0;
    end else if (!stall) begin
      // NOTE: non-blocking so every register samples pre-edge values of r_pc.
      r_pc      <= w_next_pc;
      r_retired <= r_retired + 32'd1;
      if (w_misaligned) begin
        r_epc <= r_pc;
      end
    end
  end

  // Trap flag: a new trap outranks an acknowledge in the same cycle, and an
  // acknowledge is accepted even while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap_pending <= 1'b0;
    end else if (!stall && w_misaligned) begin
      r_trap_pending <= 1'b1;
    end else if (trap_ack) begin
      r_trap_pending <= 1'b0;
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign taken        = w_taken;
  assign trap_pending = r_trap_pending;
  assign epc          = r_epc;
  assign retired      = r_retired;

endmodule

// File: tb/tb_riscv_next_pc.sv
// tb_riscv_next_pc -- directed test of riscv_next_pc against a behavioural
// model of the next-PC rules, plus literal expectations for key scenarios.
module tb_riscv_next_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [2:0]  funct3;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        zero;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        trap_pending;
  logic [31:0] epc;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_tp;
  logic [31:0] m_ret;

  riscv_next_pc #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .funct3(funct3),
    .jal(jal), .jalr(jalr), .imm(imm), .alu_out(alu_out), .zero(zero),
    .trap_ack(trap_ack), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
    .trap_pending(trap_pending), .epc(epc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Does the current instruction transfer control?
  function automatic bit m_taken(input bit br, input bit [2:0] f3, input bit j,
                                 input bit jr, input bit [31:0] alu, input bit z);
    bit c;
    if (f3 == 3'b000)      c = z;
    else if (f3 == 3'b001) c = !z;
    else if (f3 == 3'b100 || f3 == 3'b110) c = alu[0];
    else if (f3 == 3'b101 || f3 == 3'b111) c = !alu[0];
    else                   c = 0;
    return jr || j || (br && c);
  endfunction

  function automatic bit [31:0] m_target(input bit [31:0] cur, input bit jr,
                                         input bit [31:0] im, input bit [31:0] alu);
    if (jr) return alu & 32'hFFFF_FFFE;
    return cur + im;
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    bit        t;
    bit [31:0] tgt;
    if (!rst_n) begin
      m_pc  <= RESET_PC;
      m_epc <= 32'd0;
      m_tp  <= 1'b0;
      m_ret <= 32'd0;
    end else begin
      t   = m_taken(branch, funct3, jal, jalr, alu_out, zero);
      tgt = m_target(m_pc, jalr, imm, alu_out);
      if (trap_ack) m_tp <= 1'b0;
      if (!stall) begin
        m_ret <= m_ret + 32'd1;
        if (t && tgt[1:0] != 2'b00) begin
          m_pc  <= TRAP_VEC;
          m_epc <= m_pc;
          m_tp  <= 1'b1;
        end else if (t) begin
          m_pc <= tgt;
        end else begin
          m_pc <= m_pc + 32'd4;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("taken", {31'd0, taken},
            {31'd0, m_taken(branch, funct3, jal, jalr, alu_out, zero)});
      check("trap_pending", {31'd0, trap_pending}, {31'd0, m_tp});
      check("epc", epc, m_epc);
      check("retired", retired, m_ret);
    end
  end

  // Apply one cycle's inputs just after the falling edge
  task automatic drive(input bit rst, input bit stl, input bit br, input bit [2:0] f3,
                       input bit j, input bit jr, input bit [31:0] im,
                       input bit [31:0] alu, input bit z, input bit ack);
    @(negedge clk);
    #1;
    rst_n = rst; stall = stl; branch = br; funct3 = f3; jal = j; jalr = jr;
    imm = im; alu_out = alu; zero = z; trap_ack = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic nop();
    drive(1, 0, 0, 3'b000, 0, 0, 32'd0, 32'd0, 0, 0);
    tick();
  endtask

  task automatic jump(input bit [31:0] off);
    drive(1, 0, 0, 3'b000, 1, 0, off, 32'd0, 0, 0);
    tick();
  endtask

  initial begin
    logic [31:0] ret_hold;
    rst_n = 0; stall = 0; branch = 0; funct3 = 0; jal = 0; jalr = 0;
    imm = 0; alu_out = 0; zero = 0; trap_ack = 0;

    // Reset with stall and a taken jump present; reset must win
    drive(0, 1, 0, 3'b000, 1, 0, 32'h40, 32'd0, 0, 1);
    tick();
    check_en = 1'b1;
    check("reset pc", pc, 32'h0);
    check("reset retired", retired, 32'h0);
    check("reset epc", epc, 32'h0);
    check("reset trap", {31'd0, trap_pending}, 32'h0);

    // Three sequential cycles
    nop(); check("seq pc1", pc, 32'h4);
    nop(); check("seq pc2", pc, 32'h8);
    nop(); check("seq pc3", pc, 32'hC);
    check("seq retired", retired, 32'd3);
    nop(); check("seq pc4", pc, 32'h10);

    // BEQ taken / not taken from 0x10
    drive(1, 0, 1, 3'b000, 0, 0, 32'h20, 32'd0, 1, 0);
    check("beq taken", {31'd0, taken}, 32'd1);
    tick(); check("beq target", pc, 32'h30);
    jump(32'hFFFF_FFE0); check("back to 0x10", pc, 32'h10);
    drive(1, 0, 1, 3'b000, 0, 0, 32'h20, 32'd0, 0, 0);
    check("beq not taken", {31'd0, taken}, 32'd0);
    tick(); check("beq fallthrough", pc, 32'h14);

    // BLT / BGE from 0x40
    jump(32'h2C); check("to 0x40", pc, 32'h40);
    drive(1, 0, 1, 3'b100, 0, 0, 32'hFFFF_FFF8, 32'd1, 0, 0);
    tick(); check("blt target", pc, 32'h38);
    jump(32'h8);
    drive(1, 0, 1, 3'b101, 0, 0, 32'hFFFF_FFF8, 32'd1, 0, 0);
    tick(); check("bge fallthrough", pc, 32'h44);

    // Other branch flavours, checked by the model only
    drive(1, 0, 1, 3'b001, 0, 0, 32'h10, 32'd0, 0, 0); tick();   // BNE taken
    drive(1, 0, 1, 3'b110, 0, 0, 32'h8, 32'd0, 1, 0); tick();    // BLTU not taken
    drive(1, 0, 1, 3'b111, 0, 0, 32'h8, 32'd0, 0, 0); tick();    // BGEU taken
    drive(1, 0, 1, 3'b010, 0, 0, 32'h8, 32'd1, 1, 0); tick();    // 010 never taken
    drive(1, 0, 0, 3'b000, 0, 0, 32'h8, 32'd0, 1, 0); tick();    // branch=0

    // Reach 0x50, then JALR with JAL also set
    jump(32'h50 - pc);
    check("to 0x50", pc, 32'h50);
    drive(1, 0, 0, 3'b000, 1, 1, 32'h4, 32'h201, 0, 0);
    check("jalr link", pc_plus4, 32'h54);
    tick(); check("jalr target", pc, 32'h200);

    // Misaligned JAL from 0x60, then acknowledge while stalled
    jump(32'h60 - 32'h200); check("to 0x60", pc, 32'h60);
    jump(32'h6);
    check("trap pc", pc, TRAP_VEC);
    check("trap epc", epc, 32'h60);
    check("trap set", {31'd0, trap_pending}, 32'd1);
    drive(1, 1, 0, 3'b000, 0, 0, 32'd0, 32'd0, 0, 1);
    tick();
    check("ack in stall", {31'd0, trap_pending}, 32'd0);
    check("ack stall pc", pc, 32'h100);

    // New trap together with an acknowledge: new trap wins
    jump(32'h2);                                   // 0x102 -> trap, epc 0x100
    nop();                                         // pc 0x104, still pending
    drive(1, 0, 0, 3'b000, 1, 0, 32'h2, 32'd0, 0, 1);
    tick();
    check("ack+trap pending", {31'd0, trap_pending}, 32'd1);
    check("ack+trap epc", epc, 32'h104);
    drive(1, 0, 0, 3'b000, 0, 0, 32'd0, 32'd0, 0, 1); tick();

    // JALR target with bit 1 set traps; stalled misaligned jump does not
    drive(1, 0, 0, 3'b000, 0, 1, 32'd0, 32'h203, 0, 0); tick();
    check("jalr misaligned", pc, TRAP_VEC);
    drive(1, 1, 0, 3'b000, 1, 0, 32'h2, 32'd0, 0, 1);
    check("stall taken", {31'd0, taken}, 32'd1);
    tick();
    check("stall no trap", {31'd0, trap_pending}, 32'd0);

    // Wrap at the top of the address space
    drive(1, 0, 0, 3'b000, 0, 1, 32'd0, 32'hFFFF_FFFC, 0, 0); tick();
    check("to top", pc, 32'hFFFF_FFFC);
    check("top link", pc_plus4, 32'h0);
    nop(); check("wrap pc", pc, 32'h0);

    // Trap pending, stall two cycles, then reset during the stall
    nop();
    jump(32'h2);
    check("pre-stall epc", epc, 32'h4);
    ret_hold = m_ret;
    drive(1, 1, 0, 3'b000, 1, 0, 32'h40, 32'd0, 0, 0); tick();
    tick();
    check("stall pc", pc, 32'h100);
    check("stall retired", retired, ret_hold);
    drive(0, 1, 0, 3'b000, 1, 0, 32'h40, 32'd0, 0, 0); tick();
    check("mid reset pc", pc, 32'h0);
    check("mid reset retired", retired, 32'h0);
    check("mid reset trap", {31'd0, trap_pending}, 32'h0);
    check("mid reset epc", epc, 32'h0);
    nop();
    check("post reset pc", pc, 32'h4);
    check("post reset retired", retired, 32'd1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_next_pc.md
RISCV_NEXT_PC -- requirements
Module: riscv_next_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, PC loaded on misaligned-target trap.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  high = hold all state this cycle.
REQ-006 SHALL have port branch  input  1  current instruction is conditional branch.
REQ-007 SHALL have port funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 SHALL have port jal  input  1  current instruction is JAL.
REQ-009 SHALL have port jalr  input  1  current instruction is JALR.
REQ-010 SHALL have port imm  input  32  sign-extended branch/JAL offset.
REQ-011 SHALL have port alu_out  input  32  ALU result (JALR target, or SLT/SLTU result for BLT-class).
REQ-012 SHALL have port zero  input  1  ALU zero flag (SUB result for BEQ/BNE).
REQ-013 SHALL have port trap_ack  input  1  clears pending trap.
REQ-014 SHALL have port pc  output  32  registered current PC.
REQ-015 SHALL have port pc_plus4  output  32  pc + 4, combinational, link value.
REQ-016 SHALL have port taken  output  1  combinational, control transfer this cycle.
REQ-017 SHALL have port trap_pending  output  1  registered, misaligned-target trap outstanding.
REQ-018 SHALL have port epc  output  32  registered PC of faulting instruction.
REQ-019 SHALL have port retired  output  32  registered count of non-stalled cycles.

Function
REQ-020 Branch condition SHALL be: BEQ zero; BNE !zero; BLT/BLTU alu_out[0]; BGE/BGEU !alu_out[0]; funct3 010/011 never taken.
REQ-021 taken SHALL = jalr | jal | (branch & condition); independent of stall.
REQ-022 Target SHALL be: jalr -> {alu_out[31:1],1'b0}; else jal or taken branch -> pc + imm; priority jalr > jal > branch.
REQ-023 All adds SHALL be 32-bit modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000, no overflow flag).
REQ-024 Misaligned SHALL = taken & (target[1:0] != 2'b00).
REQ-025 Non-stalled, not taken: next pc SHALL = pc_plus4.
REQ-026 Non-stalled, taken, aligned: next pc SHALL = target.
REQ-027 Non-stalled, misaligned: next pc SHALL = TRAP_VEC, epc <= pc, trap_pending <= 1.
REQ-028 trap_ack SHALL clear trap_pending next edge, honoured even when stalled.
REQ-029 Simultaneous trap_ack and new misaligned trap SHALL leave trap_pending = 1 with epc updated (new trap wins).
REQ-030 stall = 1 SHALL hold pc, epc, retired; no trap raised; taken still reflects inputs.
REQ-031 retired SHALL increment by 1 each non-stalled cycle, wrapping 0xFFFFFFFF -> 0.
REQ-032 Latency: pc update SHALL appear one cycle after the decision cycle; no internal pipelining.

Reset
REQ-033 rst_n low at clk edge SHALL set pc = RESET_PC, epc = 0, trap_pending = 0, retired = 0, overriding stall, trap_ack and any taken transfer.
REQ-034 Reset asserted mid-operation (e.g. during pending trap or stall) SHALL discard all state; first post-reset cycle fetches RESET_PC.
REQ-035 Release of rst_n SHALL take effect on the next edge with no extra idle cycles.

Verification
REQ-036 Reset, then 3 non-stalled cycles, no control -> pc 0x0, 0x4, 0x8, 0xC; retired = 3.
REQ-037 pc = 0x10, branch=1, funct3=000, zero=1, imm=0x20 -> taken=1, next pc 0x30; same with zero=0 -> 0x14.
REQ-038 pc = 0x40, branch=1, funct3=100, alu_out=1, imm=-8 -> next pc 0x38; funct3=101 same inputs -> 0x44.
REQ-039 pc = 0x50, jalr=1, jal=1, alu_out=0x201 -> next pc 0x200 (jalr priority, bit0 cleared); pc_plus4 = 0x54.
REQ-040 pc = 0x60, jal=1, imm=0x6 -> next pc 0x100, epc 0x60, trap_pending=1; then trap_ack=1 with stall=1 -> trap_pending 0, pc stays 0x100.
REQ-041 pc = 0xFFFFFFFC, no control -> next pc 0x0; stall=1 for 2 cycles -> pc, retired unchanged; rst_n=0 during stall -> pc 0x0, retired 0.
